// File: rtl/oam_dma.sv
// oam_dma: 256x8 sprite attribute memory with the $2003/$2004 CPU register port,
// the $4014 page-copy DMA engine that stalls the CPU, and a read-only PPU port.
module oam_dma #(
   parameter logic [15:0] DMA_REG     = 16'h4014,
   parameter logic [15:0] OAM_ADR_REG = 16'h2003,
   parameter logic [15:0] OAM_DAT_REG = 16'h2004
) (
   input  logic        CLK25,
   input  logic        RESET,
   input  logic        CPUCE,
   input  logic [15:0] ea,
   input  logic [7:0]  din,
   input  logic        WREQ,
   input  logic        RD,
   output logic [7:0]  DOUT,
   output logic        HALT,
   output logic [15:0] DADDR,
   output logic        DRD,
   input  logic [7:0]  MDATA,
   output logic [7:0]  SPRADR,
   input  logic [7:0]  oaddr,
   output logic [7:0]  odata
);

   typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;

   state_t     state, state_nxt;
   logic [7:0] oam [256];
   logic [7:0] page;
   logic [7:0] cnt;
   logic [7:0] dbuf;
   logic       par;
   logic       idle;
   logic       cpu_adr_wr;
   logic       cpu_dat_wr;
   logic       cpu_dat_rd;
   logic       dma_start;
   logic       dma_wr;
   logic       oam_we;
   logic [7:0] oam_wdata;
   logic [7:0] rdata;

   // CPU register strobes are honoured only while the DMA engine is idle
   assign idle       = (state == IDLE);
   assign cpu_adr_wr = CPUCE && idle && WREQ && (ea == OAM_ADR_REG);
   assign cpu_dat_wr = CPUCE && idle && WREQ && (ea == OAM_DAT_REG);
   assign cpu_dat_rd = CPUCE && idle && RD   && (ea == OAM_DAT_REG);
   assign dma_start  = CPUCE && idle && WREQ && (ea == DMA_REG);
   assign dma_wr     = CPUCE && (state == WRITE);
   assign oam_we     = cpu_dat_wr || dma_wr;
   assign oam_wdata  = dma_wr ? dbuf : din;

   always_ff @(posedge CLK25) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (dma_start) state_nxt = ALIGN;
         ALIGN: if (CPUCE && par) state_nxt = READ;
         READ:  if (CPUCE) state_nxt = WRITE;
         WRITE: if (CPUCE) state_nxt = (cnt == 8'hFF) ? IDLE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      HALT  = (state != IDLE);
      DRD   = (state == READ);
      DADDR = {page, cnt};
   end

   // Attribute byte 2 has no storage behind bits 4:2, so they read back as zero
   always_comb begin
      rdata = oam[SPRADR];
      if (SPRADR[1:0] == 2'd2)
         rdata[4:2] = 3'b000;
   end

   always_ff @(posedge CLK25) begin
      if (RESET) begin
         par    <= 1'b0;
         SPRADR <= 8'h00;
         page   <= 8'h00;
         cnt    <= 8'h00;
         dbuf   <= 8'h00;
         DOUT   <= 8'h00;
      end else if (CPUCE) begin
         par <= ~par;
         if (cpu_adr_wr)
            SPRADR <= din;
         else if (oam_we)
            SPRADR <= SPRADR + 8'd1;
         if (dma_start) begin
            page <= din;
            cnt  <= 8'h00;
         end else if (dma_wr) begin
            cnt <= cnt + 8'd1;
         end
         if (state == READ)
            dbuf <= MDATA;
         if (cpu_dat_rd)
            DOUT <= rdata;
      end
   end

   // Sprite memory contents deliberately survive reset
   always_ff @(posedge CLK25) begin
      if (oam_we)
         oam[SPRADR] <= oam_wdata;
   end

   always_ff @(posedge CLK25) begin
      if (RESET)
         odata <= 8'h00;
      else
         odata <= oam[oaddr];
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized bench for oam_dma; a spec-level model predicts every
// clock's outputs into a scoreboard that a separate monitor drains and compares.
module tb_oam_dma;

   logic        CLK25 = 1'b0;
   logic        RESET;
   logic        CPUCE;
   logic [15:0] ea;
   logic [7:0]  din;
   logic        WREQ;
   logic        RD;
   logic [7:0]  DOUT;
   logic        HALT;
   logic [15:0] DADDR;
   logic        DRD;
   logic [7:0]  MDATA;
   logic [7:0]  SPRADR;
   logic [7:0]  oaddr;
   logic [7:0]  odata;

   logic [7:0]  mem [65536];

   oam_dma dut (
      .CLK25 (CLK25),
      .RESET (RESET),
      .CPUCE (CPUCE),
      .ea    (ea),
      .din   (din),
      .WREQ  (WREQ),
      .RD    (RD),
      .DOUT  (DOUT),
      .HALT  (HALT),
      .DADDR (DADDR),
      .DRD   (DRD),
      .MDATA (MDATA),
      .SPRADR(SPRADR),
      .oaddr (oaddr),
      .odata (odata)
   );

   assign MDATA = mem[DADDR];

   always #5 CLK25 = ~CLK25;

   typedef struct {
      logic [7:0]  odata;
      bit          chkOdata;
      bit          halt;
      bit          drd;
      logic [15:0] daddr;
      logic [7:0]  spr;
   } exp_t;

   exp_t       clkQ[$];
   logic [7:0] doutQ[$];

   // Reference model: OAM image, address register, and DMA progress in CPU cycles
   logic [7:0] moam [256];
   bit         mvalid [256];
   logic [7:0] mspr;
   logic [7:0] mdout;
   logic [7:0] mpage;
   bit         mpar;
   int         dmaK;
   int         align;
   logic [7:0] sweep;
   bit         randomOaddr;
   int         checks;
   int         errors;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mkExp(input logic [7:0] od, input bit odv);
      exp_t e;
      e.odata    = od;
      e.chkOdata = odv;
      e.halt     = (dmaK >= 0);
      e.drd      = (dmaK >= align) && (((dmaK - align) % 2) == 0);
      e.daddr    = {mpage, 8'((dmaK - align) / 2)};
      e.spr      = mspr;
      return e;
   endfunction

   // One CPU cycle of spec behaviour: DMA byte i lands at cycle align+2+2i after acceptance
   function automatic void modelCpuce(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
      bit pOld;
      int i;
      pOld = mpar;
      mpar = !mpar;
      if (dmaK >= 0) begin
         dmaK++;
         if (dmaK >= align + 2 && ((dmaK - align) % 2) == 0) begin
            i = (dmaK - align - 2) / 2;
            moam[mspr]   = mem[{mpage, 8'(i)}];
            mvalid[mspr] = 1'b1;
            mspr         = mspr + 8'd1;
         end
         if (dmaK == align + 512)
            dmaK = -1;
      end else begin
         if (r && a == 16'h2004) begin
            mdout = moam[mspr];
            if (mspr[1:0] == 2'd2)
               mdout[4:2] = 3'b000;
         end
         if (w && a == 16'h2003) begin
            mspr = d;
         end else if (w && a == 16'h2004) begin
            moam[mspr]   = d;
            mvalid[mspr] = 1'b1;
            mspr         = mspr + 8'd1;
         end else if (w && a == 16'h4014) begin
            mpage = d;
            align = pOld ? 2 : 1;
            dmaK  = 0;
         end
      end
   endfunction

   task automatic clockStep(input bit ce);
      logic [7:0] oa;
      logic [7:0] od;
      bit         odv;
      oa = randomOaddr ? 8'($urandom) : sweep;
      sweep = sweep + 8'd1;
      oaddr = oa;
      od    = moam[oa];
      odv   = mvalid[oa];
      CPUCE = ce;
      if (ce) begin
         modelCpuce(WREQ, RD, ea, din);
         if (RD)
            doutQ.push_back(mdout);
      end
      clkQ.push_back(mkExp(od, odv));
      @(negedge CLK25);
   endtask

   task automatic applyStimulus(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d);
      WREQ = w;
      RD   = r;
      ea   = a;
      din  = d;
      clockStep(1'b1);
      WREQ = 1'b0;
      RD   = 1'b0;
      ea   = 16'h0000;
      clockStep(1'b0);
      clockStep(1'b0);
   endtask

   task automatic applyReset(input int n);
      repeat (n) begin
         RESET = 1'b1;
         CPUCE = 1'b0;
         oaddr = sweep;
         sweep = sweep + 8'd1;
         mspr  = 8'h00;
         dmaK  = -1;
         mpar  = 1'b0;
         mdout = 8'h00;
         clkQ.push_back(mkExp(8'h00, 1'b1));
         @(negedge CLK25);
      end
      RESET = 1'b0;
   endtask

   task automatic runDma(input logic [7:0] pg, input bit wantPar, input bit lockout);
      if (mpar != wantPar)
         applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      applyStimulus(1'b1, 1'b0, 16'h4014, pg);
      while (dmaK >= 0) begin
         if (lockout && dmaK == 50)
            applyStimulus(1'b1, 1'b0, 16'h2003, 8'h40);
         else if (lockout && dmaK == 61)
            applyStimulus(1'b1, 1'b0, 16'h4014, 8'h07);
         else if (lockout && dmaK == 72)
            applyStimulus(1'b1, 1'b0, 16'h2004, 8'h99);
         else if (lockout && dmaK == 83)
            applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
         else
            applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      end
   endtask

   task automatic randomPhase(input int n);
      logic [15:0] other [4];
      other[0] = 16'h2002;
      other[1] = 16'h2005;
      other[2] = 16'h4016;
      other[3] = 16'h3004;
      randomOaddr = 1'b1;
      repeat (n) begin
         case ($urandom_range(0, 5))
            0: applyStimulus(1'b0, 1'b0, 16'h0000, 8'($urandom));
            1: applyStimulus(1'b1, 1'b0, 16'h2003, 8'($urandom));
            2: applyStimulus(1'b1, 1'b0, 16'h2004, 8'($urandom));
            3: applyStimulus(1'b1, 1'b0, other[$urandom_range(0, 3)], 8'($urandom));
            4: applyStimulus(1'b0, 1'b1, other[$urandom_range(0, 3)], 8'h00);
            default: applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
         endcase
      end
      randomOaddr = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   // Monitor: compares every clock's prediction, plus DOUT after each read strobe
   initial begin
      exp_t e;
      bit   sawRd;
      logic [7:0] dexp;
      forever begin
         @(posedge CLK25);
         sawRd = (CPUCE === 1'b1) && (RD === 1'b1);
         #1;
         if (clkQ.size() > 0) begin
            e = clkQ.pop_front();
            checkOutput("HALT", {15'd0, HALT}, {15'd0, e.halt});
            checkOutput("DRD", {15'd0, DRD}, {15'd0, e.drd});
            if (e.drd)
               checkOutput("DADDR", DADDR, e.daddr);
            checkOutput("SPRADR", {8'd0, SPRADR}, {8'd0, e.spr});
            if (e.chkOdata)
               checkOutput("odata", {8'd0, odata}, {8'd0, e.odata});
         end
         if (sawRd) begin
            if (doutQ.size() == 0) begin
               checkOutput("DOUT queue empty", 16'd1, 16'd0);
            end else begin
               dexp = doutQ.pop_front();
               checkOutput("DOUT", {8'd0, DOUT}, {8'd0, dexp});
            end
         end
      end
   end

   initial begin
      checks      = 0;
      errors      = 0;
      sweep       = 8'h00;
      randomOaddr = 1'b0;
      mspr        = 8'h00;
      mdout       = 8'h00;
      mpage       = 8'h00;
      mpar        = 1'b0;
      dmaK        = -1;
      align       = 1;
      RESET       = 1'b0;
      CPUCE       = 1'b0;
      WREQ        = 1'b0;
      RD          = 1'b0;
      ea          = 16'h0000;
      din         = 8'h00;
      oaddr       = 8'h00;
      for (int i = 0; i < 256; i++) begin
         moam[i]   = 8'h00;
         mvalid[i] = 1'b0;
      end
      for (int i = 0; i < 65536; i++)
         mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++)
         mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

      @(negedge CLK25);
      applyReset(3);
      checkOutput("DOUT reset", {8'd0, DOUT}, 16'h0000);

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h00);
      for (int i = 0; i < 256; i++)
         applyStimulus(1'b1, 1'b0, 16'h2004, 8'($urandom));

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'hFE);
      applyStimulus(1'b1, 1'b0, 16'h2004, 8'h11);
      applyStimulus(1'b1, 1'b0, 16'h2004, 8'h22);
      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h02);
      applyStimulus(1'b1, 1'b0, 16'h2004, 8'hFF);
      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h02);
      applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
      applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
      applyStimulus(1'b1, 1'b0, 16'h2003, 8'hFE);
      applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
      randomPhase(150);

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h00);
      runDma(8'h02, 1'b0, 1'b0);
      idleCycles(4);

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h10);
      runDma(8'h03, 1'b1, 1'b0);
      idleCycles(4);

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'($urandom));
      runDma(8'h04, 1'($urandom), 1'b1);
      applyStimulus(1'b0, 1'b1, 16'h2004, 8'h00);
      randomPhase(100);

      applyStimulus(1'b1, 1'b0, 16'h2003, 8'h80);
      applyStimulus(1'b1, 1'b0, 16'h4014, 8'h05);
      while (dmaK >= 0 && dmaK < align + 200)
         applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
      applyReset(1);
      idleCycles(90);

      runDma(8'h06, 1'($urandom), 1'b0);
      randomPhase(100);
      idleCycles(90);

      if (doutQ.size() != 0)
         checkOutput("DOUT leftover", 16'(doutQ.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
